// File: rtl/mul_seq.sv
// Sequential shift-and-add unsigned multiplier: one conditional WIDTH-bit add per
// clock, full 2*WIDTH-bit product after WIDTH RUN cycles.
module mul_seq #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // state | meaning
  // IDLE  | waiting for start; product holds the last result
  // RUN   | one shift-and-add step per clock, WIDTH steps in total

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;

  // Carry-out is kept as the extra MSB so the shifted accumulator never truncates.
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]};
    if (p[0]) sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
  end

  assign product = p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      m     <= '0;
      p     <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            p     <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          p   <= {sum, p[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and sweep bench for mul_seq at WIDTH=6 and WIDTH=8.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start6, start8;
  logic [5:0]  a6, b6;
  logic [7:0]  a8, b8;
  logic        busy6, done6, busy8, done8;
  logic [11:0] prod6;
  logic [15:0] prod8;

  int n_cmp;
  int n_err;

  mul_seq #(.WIDTH(6)) u6 (
    .clk(clk), .rst(rst), .start(start6), .a(a6), .b(b6),
    .busy(busy6), .done(done6), .product(prod6)
  );

  mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called right after the negedge at which start6 was dropped; lat counts
  // posedges since the start-sampling edge.
  task automatic wait_done6(output logic [11:0] prod, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done6 && lat < 20) begin
      if (busy6) busy_n++;
      @(negedge clk);
      lat++;
    end
    prod = prod6;
  endtask

  task automatic do_mul6(input logic [5:0] av, input logic [5:0] bv,
                         output logic [11:0] prod, output int lat, output int busy_n);
    @(negedge clk);
    a6 = av; b6 = bv; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    a6 = ~av; b6 = 6'h2A;
    wait_done6(prod, lat, busy_n);
  endtask

  task automatic do_mul8(input logic [7:0] av, input logic [7:0] bv,
                         output logic [15:0] prod, output int lat);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'h5A; b8 = ~bv;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    prod = prod8;
  endtask

  task automatic test_reset;
    rst = 1'b1; start6 = 1'b0; start8 = 1'b0;
    a6 = '0; b6 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy6 !== 1'b0 || done6 !== 1'b0 || prod6 !== 12'd0) begin
      n_err++;
      $display("FAIL reset6 got busy=%b done=%b prod=%0d exp 0/0/0", busy6, done6, prod6);
    end
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'd0) begin
      n_err++;
      $display("FAIL reset8 got busy=%b done=%b prod=%0d exp 0/0/0", busy8, done8, prod8);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    int ndone;
    @(negedge clk);
    a6 = 6'd63; b6 = 6'd63; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy6 !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_busy_before got %b exp 1", busy6);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy6 !== 1'b0 || done6 !== 1'b0 || prod6 !== 12'd0) begin
      n_err++;
      $display("FAIL midrst_async got busy=%b done=%b prod=%0d exp 0/0/0", busy6, done6, prod6);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done6 || busy6) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL midrst_no_done got %0d active cycles exp 0", ndone);
    end
  endtask

  task automatic test_max;
    logic [11:0] prod;
    int lat, busy_n;
    do_mul6(6'd63, 6'd63, prod, lat, busy_n);
    n_cmp++;
    if (prod !== 12'hF81) begin
      n_err++;
      $display("FAIL max_product got %0d exp 3969", prod);
    end
    n_cmp++;
    if (lat != 6 || busy_n != 6) begin
      n_err++;
      $display("FAIL max_timing got lat=%0d busy=%0d exp 6/6", lat, busy_n);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done6 !== 1'b0 || prod6 !== 12'hF81) begin
      n_err++;
      $display("FAIL max_hold got done=%b prod=%0d exp 0/3969", done6, prod6);
    end
  endtask

  task automatic test_identity;
    logic [5:0]  va [4] = '{6'd0, 6'd1, 6'd45, 6'd21};
    logic [5:0]  vb [4] = '{6'd45, 6'd45, 6'd1, 6'd2};
    logic [11:0] ve [4] = '{12'd0, 12'd45, 12'd45, 12'd42};
    logic [11:0] prod;
    int lat, busy_n;
    for (int i = 0; i < 4; i++) begin
      do_mul6(va[i], vb[i], prod, lat, busy_n);
      n_cmp++;
      if (prod !== ve[i] || lat != 6) begin
        n_err++;
        $display("FAIL identity[%0d] got prod=%0d lat=%0d exp %0d/6", i, prod, lat, ve[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy;
    int ndone, done_lat, busy_n;
    logic [11:0] prod;
    @(negedge clk);
    a6 = 6'd5; b6 = 6'd7; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    ndone = 0; done_lat = -1; busy_n = 0; prod = '0;
    for (int c = 0; c < 16; c++) begin
      if (busy6) busy_n++;
      if (done6) begin
        ndone++;
        done_lat = c;
        prod = prod6;
      end
      if (c == 2) begin
        a6 = 6'd9; b6 = 6'd9; start6 = 1'b1;
      end else begin
        start6 = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ndone != 1 || done_lat != 6) begin
      n_err++;
      $display("FAIL busy_start_done got count=%0d lat=%0d exp 1/6", ndone, done_lat);
    end
    n_cmp++;
    if (prod !== 12'd35 || busy_n != 6) begin
      n_err++;
      $display("FAIL busy_start_result got prod=%0d busy=%0d exp 35/6", prod, busy_n);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] prod;
    int lat, busy_n;
    do_mul6(6'd10, 6'd12, prod, lat, busy_n);
    n_cmp++;
    if (prod !== 12'd120 || lat != 6) begin
      n_err++;
      $display("FAIL b2b_first got prod=%0d lat=%0d exp 120/6", prod, lat);
    end
    a6 = 6'd3; b6 = 6'd50; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    a6 = 6'd0; b6 = 6'd0;
    n_cmp++;
    if (done6 !== 1'b0 || busy6 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept got done=%b busy=%b exp 0/1", done6, busy6);
    end
    wait_done6(prod, lat, busy_n);
    n_cmp++;
    if (prod !== 12'd150 || lat != 6) begin
      n_err++;
      $display("FAIL b2b_second got prod=%0d lat=%0d exp 150/6", prod, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep6;
    logic [11:0] prod, exp_p;
    int lat, busy_n, bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        exp_p = 12'(i * j);
        do_mul6(6'(i), 6'(j), prod, lat, busy_n);
        @(negedge clk);
        n_cmp++;
        if (prod !== exp_p || lat != 6 || done6 !== 1'b0) begin
          n_err++;
          if (bad < 10)
            $display("FAIL sweep6 %0d*%0d got prod=%0d lat=%0d done_after=%b exp %0d/6/0",
                     i, j, prod, lat, done6, exp_p);
          bad++;
        end
      end
    end
  endtask

  task automatic test_sweep8;
    logic [7:0]  va, vb;
    logic [15:0] prod, exp_p;
    int lat, bad;
    bad = 0;
    for (int k = 0; k < 202; k++) begin
      if (k == 0) begin
        va = 8'd255; vb = 8'd255;
      end else if (k == 1) begin
        va = 8'd128; vb = 8'd2;
      end else begin
        va = 8'($urandom_range(0, 255));
        vb = 8'($urandom_range(0, 255));
      end
      exp_p = 16'({8'd0, va} * {8'd0, vb});
      do_mul8(va, vb, prod, lat);
      @(negedge clk);
      n_cmp++;
      if (prod !== exp_p || lat != 8 || done8 !== 1'b0) begin
        n_err++;
        if (bad < 10)
          $display("FAIL sweep8 %0d*%0d got prod=%0d lat=%0d done_after=%b exp %0d/8/0",
                   va, vb, prod, lat, done8, exp_p);
        bad++;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_reset_mid;
    test_max;
    test_identity;
    test_start_while_busy;
    test_back_to_back;
    test_sweep6;
    test_sweep8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Sequential shift-and-add unsigned multiplier for the ALU datapath. It takes two WIDTH-bit operands and produces a 2*WIDTH-bit product, performing one conditional WIDTH-bit add per clock. It sits upstream of the ALU result mux and reuses the same carry/add arithmetic as the team's WIDTH-bit adder stage. It replaces a large combinational array multiplier with WIDTH cycles of latency.

Parameters:
WIDTH, 6, operand width in bits; product is 2*WIDTH bits; must be at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to multiply a by b; sampled only in IDLE.
a  input  WIDTH  multiplicand, unsigned; latched when start is accepted.
b  input  WIDTH  multiplier, unsigned; latched when start is accepted.
busy  output  1  high while a multiplication is in progress.
done  output  1  one-cycle pulse; product is valid.
product  output  2*WIDTH  unsigned a*b; held stable from done until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, product=0, iteration counter=0, and the latched multiplicand=0. Reset takes effect immediately, with no clock required. Reset asserted mid-operation aborts the operation, and no done pulse follows.
- Internal registers: multiplicand register M (WIDTH bits), accumulator P (2*WIDTH bits), and an iteration counter of ceil(log2(WIDTH+1)) bits.
- States: IDLE and RUN.
- IDLE, start=1 at edge k:
  - M<=a.
  - P<={WIDTH zeros, b}.
  - counter<=0.
  - state<=RUN and busy<=1, visible after edge k.
- RUN, each edge:
  - If P[0]=1, compute a WIDTH+1-bit sum {carry, sum} = P[2W-1:W] + M with carry-in 0. Otherwise the sum is {0, P[2W-1:W]}.
  - Update P<={carry, sum, P[W-1:1]}, i.e. the upper half gets the sum and the whole value shifts right by one.
  - The carry-out must be kept; no truncation.
  - counter increments each edge.
  - On the edge where counter reaches WIDTH-1, i.e. the WIDTH-th RUN edge (edge k+WIDTH): the final P is written, state<=IDLE, busy<=0, done<=1.
- done is high for exactly one cycle, the cycle after edge k+WIDTH. It deasserts on the next edge regardless of start.
- product mirrors P. It is required to equal a*b only while done=1 and thereafter in IDLE. During RUN its value is don't-care to consumers.
- Latency: done is observed WIDTH cycles after the start-sampling edge. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start while busy=1 is ignored: no effect on operands, counter, or result.
- start=1 in the done cycle (already IDLE) is accepted. done still lasts only that one cycle, and the new operation begins normally.
- a and b may change freely after acceptance; only the latched values are used.
- No overflow is possible: the 2*WIDTH-bit product always holds the full result.
- No X propagation from a or b when start=0.

Test Plan:
1. Reset mid-operation: start with a=63, b=63, then assert rst 2 cycles later -> busy=0, done=0, product=0 immediately. No done pulse occurs afterward.
2. Max operands, WIDTH=6: a=63, b=63, start for 1 cycle -> busy high for 6 cycles, then done pulses 1 cycle with product=3969 (12'hF81). product is held after done.
3. Zero/identity cases: a=0, b=45 -> 0; a=1, b=45 -> 45; a=45, b=1 -> 45; a=21, b=2 -> 42. done latency is exactly 6 cycles each time.
4. start while busy: start with a=5, b=7, then pulse start with a=9, b=9 on cycle 3 -> one done only, product=35. busy never drops early.
5. Back-to-back: a=10, b=12 accepted; start with a=3, b=50 held high during the done cycle -> first done shows 120. Second op accepted that cycle, and its done arrives 6 cycles later with 150.
6. Randomized exhaustive sweep, all 4096 operand pairs at WIDTH=6 plus 200 random pairs at WIDTH=8 -> product equals the reference a*b on every done. done is never wider than 1 cycle.
